// File: rtl/kbd_pkg.sv
// Shared ps2_key field positions, scan codes and injector types.
// Used by the key injector and the ASCII mapping ROM.
package kbd_pkg;

  localparam int STB = 10;
  localparam int PRS = 9;
  localparam int EXT = 8;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_DN,
    KEY_DN,
    KEY_UP,
    SHIFT_UP,
    GAP
  } inj_state_t;

  typedef struct packed {
    logic       valid;
    logic       shift;
    logic [7:0] code;
  } key_map_t;

  function automatic key_map_t km(
    input logic       s,
    input logic [7:0] c
  );
    key_map_t m;
    m.valid = 1'b1;
    m.shift = s;
    m.code  = c;
    return m;
  endfunction

endpackage

// File: rtl/key_injector_if.sv
// ASCII character handshake feeding the key injector.
// master offers bytes, slave accepts on valid && ready.
interface key_injector_if;

  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;

  modport master (
    output char_valid,
    output char_data,
    input  char_ready
  );

  modport slave (
    input  char_valid,
    input  char_data,
    output char_ready
  );

endinterface

// File: rtl/key_injector_ascii_to_ps2.sv
// Combinational ASCII to PS/2 set-2 mapping, US layout.
// Result is {valid, shift, code}; unmapped bytes give valid=0.
module ascii_to_ps2
  import kbd_pkg::*;
(
  input  logic [7:0] ch,
  output key_map_t   map
);

  function automatic key_map_t plain(
    input logic [7:0] c
  );
    key_map_t m;
    m = '0;
    case (c)
      "a": m = km(1'b0, 8'h1C);
      "b": m = km(1'b0, 8'h32);
      "c": m = km(1'b0, 8'h21);
      "d": m = km(1'b0, 8'h23);
      "e": m = km(1'b0, 8'h24);
      "f": m = km(1'b0, 8'h2B);
      "g": m = km(1'b0, 8'h34);
      "h": m = km(1'b0, 8'h33);
      "i": m = km(1'b0, 8'h43);
      "j": m = km(1'b0, 8'h3B);
      "k": m = km(1'b0, 8'h42);
      "l": m = km(1'b0, 8'h4B);
      "m": m = km(1'b0, 8'h3A);
      "n": m = km(1'b0, 8'h31);
      "o": m = km(1'b0, 8'h44);
      "p": m = km(1'b0, 8'h4D);
      "q": m = km(1'b0, 8'h15);
      "r": m = km(1'b0, 8'h2D);
      "s": m = km(1'b0, 8'h1B);
      "t": m = km(1'b0, 8'h2C);
      "u": m = km(1'b0, 8'h3C);
      "v": m = km(1'b0, 8'h2A);
      "w": m = km(1'b0, 8'h1D);
      "x": m = km(1'b0, 8'h22);
      "y": m = km(1'b0, 8'h35);
      "z": m = km(1'b0, 8'h1A);
      "0": m = km(1'b0, 8'h45);
      "1": m = km(1'b0, 8'h16);
      "2": m = km(1'b0, 8'h1E);
      "3": m = km(1'b0, 8'h26);
      "4": m = km(1'b0, 8'h25);
      "5": m = km(1'b0, 8'h2E);
      "6": m = km(1'b0, 8'h36);
      "7": m = km(1'b0, 8'h3D);
      "8": m = km(1'b0, 8'h3E);
      "9": m = km(1'b0, 8'h46);
      " ": m = km(1'b0, SC_SPACE);
      8'h0D: m = km(1'b0, SC_ENTER);
      8'h0A: m = km(1'b0, SC_ENTER);
      ",": m = km(1'b0, 8'h41);
      ".": m = km(1'b0, 8'h49);
      "-": m = km(1'b0, 8'h4E);
      "=": m = km(1'b0, 8'h55);
      ";": m = km(1'b0, 8'h4C);
      8'h27: m = km(1'b0, 8'h52);
      "[": m = km(1'b0, 8'h54);
      "]": m = km(1'b0, 8'h5B);
      8'h5C: m = km(1'b0, 8'h5D);
      "/": m = km(1'b0, 8'h4A);
      8'h60: m = km(1'b0, 8'h0E);
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic key_map_t shifted(
    input logic [7:0] c
  );
    key_map_t m;
    m = '0;
    case (c)
      "!": m = km(1'b1, 8'h16);
      "@": m = km(1'b1, 8'h1E);
      "#": m = km(1'b1, 8'h26);
      "$": m = km(1'b1, 8'h25);
      "%": m = km(1'b1, 8'h2E);
      "^": m = km(1'b1, 8'h36);
      "&": m = km(1'b1, 8'h3D);
      "*": m = km(1'b1, 8'h3E);
      "(": m = km(1'b1, 8'h46);
      ")": m = km(1'b1, 8'h45);
      "<": m = km(1'b1, 8'h41);
      ">": m = km(1'b1, 8'h49);
      "_": m = km(1'b1, 8'h4E);
      "+": m = km(1'b1, 8'h55);
      ":": m = km(1'b1, 8'h4C);
      8'h22: m = km(1'b1, 8'h52);
      "{": m = km(1'b1, 8'h54);
      "}": m = km(1'b1, 8'h5B);
      "|": m = km(1'b1, 8'h5D);
      "?": m = km(1'b1, 8'h4A);
      "~": m = km(1'b1, 8'h0E);
      default: m = '0;
    endcase
    return m;
  endfunction

  // Capitals reuse the lowercase row with shift held.
  always_comb begin
    map = plain(ch);
    if (ch >= 8'h41 && ch <= 8'h5A) begin
      map       = plain(ch | 8'h20);
      map.shift = 1'b1;
    end else if (!map.valid) begin
      map = shifted(ch);
    end
  end

endmodule

// File: rtl/key_injector.sv
// Merges live ps2_key events with make/break events typed
// from an ASCII stream; each synthesized key state is held.
module key_injector
  import kbd_pkg::*;
#(
  parameter int         HOLD_CYCLES = 500000,
  parameter logic [7:0] SHIFT_CODE  = SC_LSHIFT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   ps2_key_in,
  output logic [10:0]   ps2_key_out,
  key_injector_if.slave chr,
  input  logic          abort,
  output logic          busy,
  output logic          unsupported
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD = CW'(HOLD_CYCLES);

  inj_state_t    state;
  inj_state_t    state_n;
  inj_state_t    nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [CW-1:0] cnt_dec;
  logic [7:0]    code_q;
  logic [7:0]    code_n;
  logic          shift_q;
  logic          shift_n;
  logic          fresh;
  logic          fresh_n;
  logic          bad_q;
  logic          bad_n;
  logic          trk;
  logic          live;
  logic          emit;
  logic [9:0]    ev;
  key_map_t      map;

  ascii_to_ps2 u_map (
    .ch  (chr.char_data),
    .map (map)
  );

  function automatic inj_state_t succ(
    input inj_state_t s,
    input logic       sh
  );
    inj_state_t r;
    r = IDLE;
    unique case (s)
      SHIFT_DN: r = KEY_DN;
      KEY_DN:   r = KEY_UP;
      KEY_UP:   r = sh ? SHIFT_UP : GAP;
      SHIFT_UP: r = GAP;
      default:  r = IDLE;
    endcase
    return r;
  endfunction

  function automatic logic [9:0] ev_of(
    input inj_state_t s,
    input logic [7:0] c
  );
    logic [9:0] e;
    e = '0;
    case (s)
      SHIFT_DN: e = {2'b10, SHIFT_CODE};
      KEY_DN:   e = {2'b10, c};
      KEY_UP:   e = {2'b00, c};
      SHIFT_UP: e = {2'b00, SHIFT_CODE};
      default:  e = '0;
    endcase
    return e;
  endfunction

  assign busy           = (state != IDLE);
  assign chr.char_ready = (state == IDLE) && !reset;
  assign live           = ps2_key_in[STB] ^ trk;
  assign cnt_dec        = cnt - CW'(1);

  // The accept edge only latches the byte; the first
  // event goes out one edge later so it never collides
  // with a live event passed through on the accept edge.
  always_comb begin
    state_n = state;
    nxt     = state;
    cnt_n   = cnt;
    code_n  = code_q;
    shift_n = shift_q;
    fresh_n = 1'b0;
    bad_n   = 1'b0;
    emit    = 1'b0;
    ev      = '0;
    unique case (state)
      IDLE: begin
        if (chr.char_valid) begin
          if (map.valid) begin
            code_n  = map.code;
            shift_n = map.shift;
            fresh_n = 1'b1;
            state_n = map.shift ? SHIFT_DN : KEY_DN;
          end else begin
            bad_n = 1'b1;
          end
        end
        if (live) begin
          emit = 1'b1;
          ev   = ps2_key_in[9:0];
        end
      end
      default: begin
        if (fresh) begin
          emit  = 1'b1;
          ev    = ev_of(state, code_q);
          cnt_n = HOLD;
        end else begin
          cnt_n = cnt_dec;
          if (abort && state == SHIFT_DN) begin
            nxt = SHIFT_UP;
          end else if (abort && state == KEY_DN) begin
            nxt = KEY_UP;
          end else if (cnt_dec == '0) begin
            nxt = succ(state, shift_q);
          end
          if (nxt != state) begin
            state_n = nxt;
            cnt_n   = (nxt == IDLE) ? '0 : HOLD;
            emit    = (nxt != GAP) && (nxt != IDLE);
            ev      = ev_of(nxt, code_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      code_q      <= '0;
      shift_q     <= 1'b0;
      fresh       <= 1'b0;
      bad_q       <= 1'b0;
      unsupported <= 1'b0;
      ps2_key_out <= '0;
      trk         <= ps2_key_in[STB];
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      code_q      <= code_n;
      shift_q     <= shift_n;
      fresh       <= fresh_n;
      bad_q       <= bad_n;
      unsupported <= bad_q;
      trk         <= ps2_key_in[STB];
      if (emit) begin
        ps2_key_out <= {~ps2_key_out[STB], ev};
      end
    end
  end

endmodule

// File: tb/tb_key_injector.sv
// Scoreboard bench for key_injector with HOLD_CYCLES=4.
// Stimulus queues expected events; a monitor checks them.
module tb_key_injector;

  logic        clk;
  logic        reset;
  logic [10:0] ps2_key_in;
  logic [10:0] ps2_key_out;
  logic        abort;
  logic        busy;
  logic        unsupported;

  key_injector_if chr ();

  key_injector #(
    .HOLD_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_key_in  (ps2_key_in),
    .ps2_key_out (ps2_key_out),
    .chr         (chr),
    .abort       (abort),
    .busy        (busy),
    .unsupported (unsupported)
  );

  typedef struct {
    int          c;
    logic [10:0] v;
  } exp_t;

  exp_t        q[$];
  logic        exp_stb;
  logic [10:0] prev;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push(
    input int         c,
    input logic       prs,
    input logic [7:0] code
  );
    exp_t e;
    exp_stb = ~exp_stb;
    e.c = c;
    e.v = {exp_stb, prs, 1'b0, code};
    q.push_back(e);
  endtask

  // Any change of ps2_key_out outside reset is an event.
  initial prev = '0;
  always @(posedge clk) begin
    logic rs;
    exp_t e;
    rs = reset;
    #1;
    if (rs) begin
      prev = ps2_key_out;
    end else if (ps2_key_out !== prev) begin
      prev = ps2_key_out;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_event: got %h at cycle %0d",
                 ps2_key_out, cyc);
      end else begin
        e = q.pop_front();
        chk("event_value", 32'(ps2_key_out), 32'(e.v));
        chk("event_cycle", cyc, e.c);
      end
    end
  end

  task automatic offer(
    input  logic [7:0] ch,
    output int         n
  );
    @(negedge clk);
    chr.char_valid = 1'b1;
    chr.char_data  = ch;
    #1 chk("accept_ready", 32'(chr.char_ready), 1);
    @(posedge clk);
    #1 n = cyc;
    @(negedge clk);
    chr.char_valid = 1'b0;
  endtask

  task automatic wait_idle(input int exp_c);
    int t;
    t = -1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        t = cyc;
        break;
      end
    end
    chk("busy_fall", t, exp_c);
  endtask

  task automatic shifted_seq(
    input logic [7:0] ch,
    input logic [7:0] code
  );
    int n;
    offer(ch, n);
    push(n + 1, 1'b1, 8'h12);
    push(n + 5, 1'b1, code);
    push(n + 9, 1'b0, code);
    push(n + 13, 1'b0, 8'h12);
    @(posedge clk);
    #1 chk("shift_ready_lo", 32'(chr.char_ready), 0);
    repeat (8) @(posedge clk);
    #1 chk("shift_ready_mid", 32'(chr.char_ready), 0);
    wait_idle(n + 21);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset          = 1'b1;
    abort          = 1'b0;
    ps2_key_in     = '0;
    chr.char_valid = 1'b0;
    chr.char_data  = '0;
    exp_stb        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(ps2_key_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_unsup", 32'(unsupported), 0);
    chk("rst_ready", 32'(chr.char_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("idle_ready", 32'(chr.char_ready), 1);

    // 'a': make then break, then gap
    offer(8'h61, n);
    push(n + 1, 1'b1, 8'h1C);
    push(n + 5, 1'b0, 8'h1C);
    wait_idle(n + 13);

    shifted_seq(8'h41, 8'h1C);
    shifted_seq(8'h21, 8'h16);

    // DEL has no mapping
    offer(8'h7F, n);
    @(posedge clk);
    #1;
    chk("unsup_pulse", 32'(unsupported), 1);
    chk("unsup_ready", 32'(chr.char_ready), 1);
    chk("unsup_busy", 32'(busy), 0);
    @(posedge clk);
    #1 chk("unsup_end", 32'(unsupported), 0);

    // live event while idle
    @(negedge clk);
    push(cyc + 1, 1'b1, 8'h29);
    ps2_key_in = {~ps2_key_in[10], 1'b1, 1'b0, 8'h29};
    repeat (2) @(posedge clk);

    // live event while busy is dropped
    offer(8'h61, n);
    push(n + 1, 1'b1, 8'h1C);
    push(n + 5, 1'b0, 8'h1C);
    repeat (2) @(posedge clk);
    @(negedge clk);
    ps2_key_in = {~ps2_key_in[10], 1'b0, 1'b0, 8'h29};
    wait_idle(n + 13);
    repeat (4) @(posedge clk);

    // abort two cycles into SHIFT_DN
    offer(8'h41, n);
    push(n + 1, 1'b1, 8'h12);
    push(n + 3, 1'b0, 8'h12);
    repeat (2) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle(n + 11);

    // reset while KEY_DN is held
    offer(8'h61, n);
    push(n + 1, 1'b1, 8'h1C);
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    exp_stb = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out", 32'(ps2_key_out), 0);
    chk("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("midrst_ready", 32'(chr.char_ready), 1);

    offer(8'h61, n);
    push(n + 1, 1'b1, 8'h1C);
    push(n + 5, 1'b0, 8'h1C);
    wait_idle(n + 13);

    repeat (3) @(posedge clk);
    #1 chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
